// File: rtl/filter_pkg.sv
// Shared types and helpers for the streaming IIR filter.
// Holds filter/FSM enums and a width-parametrised saturate function.
package filter_pkg;

  typedef enum logic [1:0] {
    LP = 2'd0,
    HP = 2'd1,
    BP = 2'd2,
    BS = 2'd3
  } filter_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } filt_state_t;

  // Clamp v into the signed range of a w-bit word.
  function automatic logic signed [31:0] saturate(
    input logic signed [31:0] v,
    input int unsigned        w
  );
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi)
      return hi;
    else if (v < lo)
      return lo;
    else
      return v;
  endfunction

endpackage

// File: rtl/iir_lp_stage.sv
// Combinational single-pole update: lp = sat(y + ((a*(x-y)) >>> COEF_W)).
// Ports: y state, x sample, a coefficient in, lp result and sat flag out.
module iir_lp_stage
  import filter_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int COEF_W = 12
) (
  input  logic signed [DATA_W-1:0] y,
  input  logic signed [DATA_W-1:0] x,
  input  logic        [COEF_W-1:0] a,
  output logic signed [DATA_W-1:0] lp,
  output logic                     sat
);

  localparam int DW1 = DATA_W + 1;
  localparam int PW  = DATA_W + COEF_W + 2;

  logic signed [DW1-1:0] diff;
  logic signed [PW-1:0]  prod;
  logic signed [PW-1:0]  step;
  logic signed [31:0]    sum;
  logic signed [31:0]    res;

  always_comb begin
    diff = DW1'(x) - DW1'(y);
    prod = PW'($signed({1'b0, a})) * PW'(diff);
    // Arithmetic shift floors toward minus infinity.
    step = prod >>> COEF_W;
    // Shifted step fits in DATA_W+1 bits, so the narrowing is lossless.
    sum  = 32'(y) + 32'(step);
    res  = saturate(sum, DATA_W);
    lp   = DATA_W'(res);
    sat  = (res != sum);
  end

endmodule

// File: rtl/iir_filter_stream.sv
// Streaming multi-channel first-order IIR filter (LP/HP/BP/BS), one
// sample per handshake; IDLE -> CALC -> OUT per sample.
// Ports: clk, rst (sync, high); mode/alpha_lo/alpha_hi/clear controls;
// s_valid/s_ready/s_data/s_chan in; m_valid/m_ready/m_data/m_chan out.
// Define IIR_FILTER_SAT_CNT_EN to add the sat_cnt[15:0] output.
module iir_filter_stream
  import filter_pkg::*;
#(
  parameter int DATA_W   = 12,
  parameter int COEF_W   = 12,
  parameter int CHANNELS = 2,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               mode,
  input  logic [COEF_W-1:0]        alpha_lo,
  input  logic [COEF_W-1:0]        alpha_hi,
  input  logic                     clear,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_data,
  input  logic [CH_W-1:0]          s_chan,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [DATA_W-1:0] m_data,
`ifdef IIR_FILTER_SAT_CNT_EN
  output logic [15:0]              sat_cnt,
`endif
  output logic [CH_W-1:0]          m_chan
);

  filt_state_t state;
  filt_state_t state_nx;

  logic signed [DATA_W-1:0] lp_lo [CHANNELS];
  logic signed [DATA_W-1:0] lp_hi [CHANNELS];

  logic signed [DATA_W-1:0] x_q;
  logic [CH_W-1:0]          ch_q;
  filter_mode_t             mode_q;
  logic [COEF_W-1:0]        alo_q;
  logic [COEF_W-1:0]        ahi_q;

  logic                     accept;
  logic                     ch_ok;
  logic [CH_W-1:0]          ch_idx;
  logic signed [DATA_W-1:0] y_lo;
  logic signed [DATA_W-1:0] y_hi;
  logic signed [DATA_W-1:0] lo;
  logic signed [DATA_W-1:0] hi;
  logic signed [DATA_W-1:0] res;
  logic                     sat_lo;
  logic                     sat_hi;
  logic                     sat_res;
  logic signed [31:0]       raw;
  logic signed [31:0]       rsat;

  assign accept = (state == IDLE) && s_valid;
  assign ch_ok  = 32'(ch_q) < CHANNELS;
  // Out-of-range channels read a harmless index and never write back.
  assign ch_idx = ch_ok ? ch_q : '0;
  assign y_lo   = lp_lo[ch_idx];
  assign y_hi   = lp_hi[ch_idx];

  iir_lp_stage #(
    .DATA_W(DATA_W),
    .COEF_W(COEF_W)
  ) u_lo (
    .y  (y_lo),
    .x  (x_q),
    .a  (alo_q),
    .lp (lo),
    .sat(sat_lo)
  );

  iir_lp_stage #(
    .DATA_W(DATA_W),
    .COEF_W(COEF_W)
  ) u_hi (
    .y  (y_hi),
    .x  (x_q),
    .a  (ahi_q),
    .lp (hi),
    .sat(sat_hi)
  );

  // Wide integer math keeps every intermediate free of wrap.
  always_comb begin
    raw = 32'(lo);
    unique case (mode_q)
      LP: raw = 32'(lo);
      HP: raw = 32'(x_q) - 32'(lo);
      BP: raw = 32'(hi) - 32'(lo);
      BS: raw = 32'(x_q) - (32'(hi) - 32'(lo));
      default: raw = 32'(lo);
    endcase
    rsat    = saturate(raw, DATA_W);
    res     = DATA_W'(rsat);
    sat_res = (rsat != raw);
  end

  always_comb begin
    state_nx = state;
    s_ready  = 1'b0;
    m_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid)
          state_nx = CALC;
      end
      CALC: state_nx = ch_ok ? OUT : IDLE;
      OUT: begin
        m_valid = 1'b1;
        if (m_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      m_data <= '0;
      m_chan <= '0;
      x_q    <= '0;
      ch_q   <= '0;
      mode_q <= LP;
      alo_q  <= '0;
      ahi_q  <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        lp_lo[c] <= '0;
        lp_hi[c] <= '0;
      end
    end else begin
      state <= state_nx;
      if (state == IDLE && clear) begin
        for (int c = 0; c < CHANNELS; c++) begin
          lp_lo[c] <= '0;
          lp_hi[c] <= '0;
        end
      end
      if (accept) begin
        x_q    <= s_data;
        ch_q   <= s_chan;
        mode_q <= filter_mode_t'(mode);
        alo_q  <= alpha_lo;
        ahi_q  <= alpha_hi;
      end
      if (state == CALC && ch_ok) begin
        lp_lo[ch_idx] <= lo;
        lp_hi[ch_idx] <= hi;
        m_data        <= res;
        m_chan        <= ch_q;
      end
    end
  end

`ifdef IIR_FILTER_SAT_CNT_EN
  logic sat_any;
  assign sat_any = sat_lo | sat_hi | sat_res;

  always_ff @(posedge clk) begin
    if (rst)
      sat_cnt <= '0;
    else if (state == IDLE && clear)
      sat_cnt <= '0;
    else if (state == CALC && ch_ok && sat_any && sat_cnt != 16'hFFFF)
      sat_cnt <= sat_cnt + 16'd1;
  end
`else
  logic sat_unused;
  assign sat_unused = sat_lo | sat_hi | sat_res;
`endif

endmodule

// File: tb/tb_iir_filter_stream.sv
// Self-checking bench for iir_filter_stream: directed plan steps plus
// randomized samples against an arithmetic reference model.
module tb_iir_filter_stream;

  logic              clk;
  logic              rst;
  logic [1:0]        mode;
  logic [11:0]       alpha_lo;
  logic [11:0]       alpha_hi;
  logic              clear;
  logic              s_valid;
  logic              s_ready;
  logic signed [11:0] s_data;
  logic [0:0]        s_chan;
  logic              m_valid;
  logic              m_ready;
  logic signed [11:0] m_data;
  logic [0:0]        m_chan;
`ifdef IIR_FILTER_SAT_CNT_EN
  logic [15:0]       sat_cnt;
  int                m_satc;
`endif

  int checks;
  int errors;
  int mlo [2];
  int mhi [2];
  int got;

  iir_filter_stream dut (
    .clk     (clk),
    .rst     (rst),
    .mode    (mode),
    .alpha_lo(alpha_lo),
    .alpha_hi(alpha_hi),
    .clear   (clear),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_chan  (s_chan),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
`ifdef IIR_FILTER_SAT_CNT_EN
    .sat_cnt (sat_cnt),
`endif
    .m_chan  (m_chan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sat(input int v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  function automatic int lpf(input int y, input int x, input int a);
    return sat(y + ((a * (x - y)) >>> 12));
  endfunction

  task automatic check(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_zero();
    for (int c = 0; c < 2; c++) begin
      mlo[c] = 0;
      mhi[c] = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_zero();
`ifdef IIR_FILTER_SAT_CNT_EN
    m_satc = 0;
`endif
  endtask

  // Called 1 time unit after a rising edge with the DUT idle.
  task automatic sample(input int ch, input int x, input int md,
                        input int alo, input int ahi, input int stall,
                        input bit clr, output int res);
    int lo_e;
    int hi_e;
    int raw;
    int exp_d;
    int lat;
    s_chan   = 1'(ch);
    s_data   = 12'(x);
    mode     = 2'(md);
    alpha_lo = 12'(alo);
    alpha_hi = 12'(ahi);
    clear    = clr;
    s_valid  = 1'b1;
    m_ready  = (stall == 0);
    check("s_ready_idle", int'(s_ready), 1);
    if (clr) begin
      model_zero();
`ifdef IIR_FILTER_SAT_CNT_EN
      m_satc = 0;
`endif
    end
    lo_e = lpf(mlo[ch], x, alo);
    hi_e = lpf(mhi[ch], x, ahi);
    case (md)
      0: raw = lo_e;
      1: raw = x - lo_e;
      2: raw = hi_e - lo_e;
      default: raw = x - (hi_e - lo_e);
    endcase
    exp_d = sat(raw);
    mlo[ch] = lo_e;
    mhi[ch] = hi_e;
`ifdef IIR_FILTER_SAT_CNT_EN
    if (exp_d != raw && m_satc < 65535)
      m_satc++;
`endif
    @(posedge clk); #1;
    s_valid = 1'b0;
    clear   = 1'b0;
    lat     = 1;
    while (!m_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, 2);
    check("m_data", int'(m_data), exp_d);
    check("m_chan", int'(m_chan), ch);
    res = int'(m_data);
    for (int i = 0; i < stall; i++) begin
      check("bp_s_ready", int'(s_ready), 0);
      @(posedge clk); #1;
      check("bp_m_valid", int'(m_valid), 1);
      check("bp_m_data", int'(m_data), exp_d);
      check("bp_m_chan", int'(m_chan), ch);
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    check("post_m_valid", int'(m_valid), 0);
    check("post_s_ready", int'(s_ready), 1);
`ifdef IIR_FILTER_SAT_CNT_EN
    check("sat_cnt", int'(sat_cnt), m_satc);
`endif
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    mode     = 2'd0;
    alpha_lo = '0;
    alpha_hi = '0;
    clear    = 1'b0;
    s_valid  = 1'b0;
    s_data   = '0;
    s_chan   = '0;
    m_ready  = 1'b1;

    do_reset();
    check("rst_s_ready", int'(s_ready), 1);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_m_data", int'(m_data), 0);
    check("rst_m_chan", int'(m_chan), 0);

    // LP step response
    sample(0, 1000, 0, 2048, 0, 0, 1'b0, got);
    check("lp_step1", got, 500);
    sample(0, 1000, 0, 2048, 0, 0, 1'b0, got);
    check("lp_step2", got, 750);
    sample(0, 1000, 0, 2048, 0, 0, 1'b0, got);
    check("lp_step3", got, 875);

    // HP step response
    do_reset();
    sample(0, 1000, 1, 2048, 0, 0, 1'b0, got);
    check("hp_step1", got, 500);
    sample(0, 1000, 1, 2048, 0, 0, 1'b0, got);
    check("hp_step2", got, 250);
    sample(0, 1000, 1, 2048, 0, 0, 1'b0, got);
    check("hp_step3", got, 125);

    // Saturation
    do_reset();
    sample(0, -2048, 1, 4095, 0, 0, 1'b0, got);
    check("sat_zero", got, 0);
    sample(0, 2047, 1, 1, 0, 0, 1'b0, got);
    check("sat_clip", got, 2047);
`ifdef IIR_FILTER_SAT_CNT_EN
    check("sat_cnt_one", int'(sat_cnt), 1);
`endif

    // Channel independence
    do_reset();
    sample(0, 1000, 0, 2048, 0, 0, 1'b0, got);
    check("ch0_a", got, 500);
    sample(1, -400, 0, 2048, 0, 0, 1'b0, got);
    check("ch1_a", got, -200);
    sample(0, 1000, 0, 2048, 0, 0, 1'b0, got);
    check("ch0_b", got, 750);
    sample(1, -400, 0, 2048, 0, 0, 1'b0, got);
    check("ch1_b", got, -300);

    // Back-pressure
    sample(1, 1500, 2, 3000, 500, 5, 1'b0, got);

    // Clear with a simultaneous sample
    sample(0, 1000, 0, 2048, 0, 0, 1'b1, got);
    check("clear_lp", got, 500);

    // Reset while in CALC
    s_chan   = 1'b0;
    s_data   = 12'sd700;
    mode     = 2'd0;
    alpha_lo = 12'd2048;
    s_valid  = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    rst     = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_zero();
`ifdef IIR_FILTER_SAT_CNT_EN
    m_satc = 0;
`endif
    check("midrst_m_valid", int'(m_valid), 0);
    check("midrst_s_ready", int'(s_ready), 1);
    check("midrst_m_data", int'(m_data), 0);
    sample(0, 1000, 0, 2048, 0, 0, 1'b0, got);
    check("midrst_lp", got, 500);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      int ch;
      int x;
      int md;
      int alo;
      int ahi;
      int st;
      bit clr;
      ch  = int'($urandom_range(0, 1));
      md  = int'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: x = 2047;
        1: x = -2048;
        default: x = int'($urandom_range(0, 4095)) - 2048;
      endcase
      case ($urandom_range(0, 4))
        0: alo = 4095;
        1: alo = 0;
        default: alo = int'($urandom_range(0, 4095));
      endcase
      ahi = int'($urandom_range(0, 4095));
      st  = int'($urandom_range(0, 2));
      clr = ($urandom_range(0, 9) == 0);
      sample(ch, x, md, alo, ahi, st, clr, got);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
